operand_b_stage: RTL and testbench

OPERAND_B_STAGE -- requirements
Module: operand_b_stage

---
 rtl/operand_b_stage.sv | 164 ++++++++++++++++
 tb/tb_operand_b_stage.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_b_stage.sv
// ---------------------------------------------------------------------------
// operand_b_stage
//   Operand-B stage between ID and EX. It selects operand B from the
//   immediate, an EX/WB forwarding path or register-file read data, and
//   registers the result for the function unit behind a valid/ready
//   handshake. A load in EX whose destination is the operand-B register
//   causes a one-cycle stall (HAZ). When the stall ends, the loaded value
//   is taken through the WB forwarding path.
//
// Ports
//   clk, reset             : clock; synchronous active-high reset
//   in_valid / in_ready    : operand handshake from the ID stage
//   B_data, constant, MB   : register read data, immediate, immediate select
//   b_addr                 : register address of operand B
//   ex_wr_en, ex_is_load,
//   ex_wr_addr, ex_result  : register write of the instruction in EX
//   wb_wr_en, wb_wr_addr,
//   wb_result              : register write of the WB stage
//   flush                  : drop the held operand (taken branch/jump)
//   out_valid / out_ready  : operand handshake to the function unit
//   out_data               : registered operand B
//   stall_count            : saturating count of load-use stall cycles
// ---------------------------------------------------------------------------
module operand_b_stage #(
    parameter int WIDTH = 16,
    parameter int AW    = 3,
    parameter int CW    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] B_data,
    input  logic [WIDTH-1:0] constant,
    input  logic             MB,
    input  logic [AW-1:0]    b_addr,
    input  logic             ex_wr_en,
    input  logic             ex_is_load,
    input  logic [AW-1:0]    ex_wr_addr,
    input  logic [WIDTH-1:0] ex_result,
    input  logic             wb_wr_en,
    input  logic [AW-1:0]    wb_wr_addr,
    input  logic [WIDTH-1:0] wb_result,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    stall_count
);

    typedef enum logic {
        RUN = 1'b0,
        HAZ = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [CW-1:0]     stall_count_q, stall_count_d;

    logic              ex_match;
    logic              wb_match;
    logic              hazard;
    logic              slot_free;
    logic              in_ready_c;
    logic              accept;
    logic [WIDTH-1:0]  sel_data;

    // Source selection and handshake qualifiers
    always_comb begin
        // Address match only counts when the stage actually writes.
        ex_match = ex_wr_en && (ex_wr_addr == b_addr);
        wb_match = wb_wr_en && (wb_wr_addr == b_addr);

        // EX beats WB because EX holds the newer value. A load in EX has no
        // data yet, so it never forwards and raises the hazard instead.
        if (MB) begin
            sel_data = constant;
        end else if (ex_match && !ex_is_load) begin
            sel_data = ex_result;
        end else if (wb_match) begin
            sel_data = wb_result;
        end else begin
            sel_data = B_data;
        end

        hazard     = !MB && in_valid && ex_match && ex_is_load;
        slot_free  = out_ready || !out_valid_q;
        in_ready_c = (state_q == RUN) && !hazard && slot_free && !reset && !flush;
        accept     = in_valid && in_ready_c;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                // Stall only once the output slot is free. Otherwise stay in
                // RUN with in_ready low and re-evaluate the next cycle.
                if (hazard && slot_free) begin
                    state_d = HAZ;
                end
            end
            HAZ: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        if (flush) begin
            state_d = RUN;
        end
    end

    // Output and datapath next-values
    always_comb begin
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        stall_count_d = stall_count_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // Saturating counter: it stops at all-ones instead of wrapping.
        if ((state_q == HAZ) && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CW'(1);
        end

        in_ready    = in_ready_c;
        out_valid   = out_valid_q;
        out_data    = out_data_q;
        stall_count = stall_count_q;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            stall_count_q <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_operand_b_stage.sv
module tb_operand_b_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready, in_ready2;
    logic [15:0] B_data, constant;
    logic        MB;
    logic [2:0]  b_addr;
    logic        ex_wr_en, ex_is_load;
    logic [2:0]  ex_wr_addr;
    logic [15:0] ex_result;
    logic        wb_wr_en;
    logic [2:0]  wb_wr_addr;
    logic [15:0] wb_result;
    logic        flush;
    logic        out_valid, out_valid2;
    logic        out_ready;
    logic [15:0] out_data, out_data2;
    logic [7:0]  stall_count;
    logic [1:0]  stall_count2;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit          m_bubble;   // a stall cycle is pending for the next cycle
    bit          m_valid;
    logic [15:0] m_data;
    int unsigned m_stall;    // unbounded count; saturation applied on compare
    bit          exp_rdy, obs_rdy, obs_rdy2;

    always #5 clk = ~clk;

    operand_b_stage #(.WIDTH(16), .AW(3), .CW(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .B_data(B_data), .constant(constant), .MB(MB), .b_addr(b_addr),
        .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_wr_addr(ex_wr_addr),
        .ex_result(ex_result), .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr),
        .wb_result(wb_result), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .stall_count(stall_count)
    );

    operand_b_stage #(.WIDTH(16), .AW(3), .CW(2)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .B_data(B_data), .constant(constant), .MB(MB), .b_addr(b_addr),
        .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_wr_addr(ex_wr_addr),
        .ex_result(ex_result), .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr),
        .wb_result(wb_result), .flush(flush), .out_valid(out_valid2),
        .out_ready(out_ready), .out_data(out_data2), .stall_count(stall_count2)
    );

    function automatic logic [15:0] ref_source();
        if (MB) return constant;
        if (ex_wr_en && ex_wr_addr == b_addr && !ex_is_load) return ex_result;
        if (wb_wr_en && wb_wr_addr == b_addr) return wb_result;
        return B_data;
    endfunction

    function automatic bit ref_hazard();
        return !MB && in_valid && ex_wr_en && ex_is_load && (ex_wr_addr == b_addr);
    endfunction

    function automatic logic [7:0] exp_stall8();
        return (m_stall > 255) ? 8'hFF : m_stall[7:0];
    endfunction

    function automatic logic [1:0] exp_stall2();
        return (m_stall > 3) ? 2'd3 : m_stall[1:0];
    endfunction

    // One clock cycle: predict in_ready, sample it mid-cycle, advance the model.
    task automatic clk_cycle();
        bit          haz, free, acc;
        bit          n_bubble, n_valid;
        logic [15:0] n_data;
        int unsigned n_stall;
        @(negedge clk);
        haz      = ref_hazard();
        free     = out_ready || !m_valid;
        exp_rdy  = !m_bubble && !haz && free && !reset && !flush;
        obs_rdy  = in_ready;
        obs_rdy2 = in_ready2;
        acc      = in_valid && exp_rdy;
        if (reset) begin
            n_bubble = 0; n_valid = 0; n_data = '0; n_stall = 0;
        end else begin
            n_stall  = m_stall + (m_bubble ? 1 : 0);
            n_bubble = !flush && !m_bubble && haz && free;
            n_data   = m_data;
            n_valid  = m_valid;
            if (flush) n_valid = 0;
            else if (acc) begin n_valid = 1; n_data = ref_source(); end
            else if (out_ready) n_valid = 0;
        end
        @(posedge clk);
        m_bubble = n_bubble; m_valid = n_valid; m_data = n_data; m_stall = n_stall;
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; in_valid = 0; MB = 0; b_addr = 0; B_data = 0; constant = 0;
        ex_wr_en = 0; ex_is_load = 0; ex_wr_addr = 0; ex_result = 0;
        wb_wr_en = 0; wb_wr_addr = 0; wb_result = 0; flush = 0; out_ready = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1; in_valid = 1; MB = 1; constant = 16'hAAAA;
        clk_cycle();
        clk_cycle();
        checks++; if (obs_rdy !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b want=0", obs_rdy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data got=%h want=0000", out_data); end
        checks++; if (stall_count !== 8'd0) begin errors++; $display("FAIL reset_stall got=%0d want=0", stall_count); end
        reset = 0; in_valid = 0;
    endtask

    task automatic test_const_select();
        idle_inputs();
        MB = 1; constant = 16'h00FF; B_data = 16'h1234; in_valid = 1; out_ready = 1;
        clk_cycle();
        checks++; if (obs_rdy !== 1'b1) begin errors++; $display("FAIL const_in_ready got=%b want=1", obs_rdy); end
        checks++; if (out_data !== 16'h00FF) begin errors++; $display("FAIL const_data got=%h want=00ff", out_data); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL const_valid got=%b want=1", out_valid); end
    endtask

    task automatic test_forwarding();
        logic [15:0] want [5];
        idle_inputs();
        in_valid = 1; MB = 0; B_data = 16'h2222;
        want = '{16'hBEEF, 16'h1111, 16'h2222, 16'h0A0A, 16'h0B0B};
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin b_addr = 3; ex_wr_en = 1; ex_wr_addr = 3; ex_result = 16'hBEEF;
                         wb_wr_en = 1; wb_wr_addr = 3; wb_result = 16'h1111; end
                1: ex_wr_en = 0;                  // address still matches, no write
                2: wb_wr_en = 0;
                3: begin b_addr = 0; wb_wr_en = 1; wb_wr_addr = 0; wb_result = 16'h0A0A; end
                default: begin ex_wr_en = 1; ex_wr_addr = 0; ex_result = 16'h0B0B; end
            endcase
            clk_cycle();
            checks++; if (out_data !== want[i] || out_valid !== 1'b1) begin
                errors++; $display("FAIL forward_%0d got=%h/%b want=%h/1", i, out_data, out_valid, want[i]); end
        end
        in_valid = 0;
        clk_cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got=%b want=0", out_valid); end
    endtask

    task automatic test_load_use();
        idle_inputs();
        in_valid = 1; MB = 0; b_addr = 2; B_data = 16'h9999;
        ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 2; ex_result = 16'hDEAD;
        clk_cycle();
        checks++; if (obs_rdy !== 1'b0) begin errors++; $display("FAIL hazard_in_ready got=%b want=0", obs_rdy); end
        checks++; if (stall_count !== 8'd0) begin errors++; $display("FAIL hazard_stall0 got=%0d want=0", stall_count); end
        ex_wr_en = 0; ex_is_load = 0;
        wb_wr_en = 1; wb_wr_addr = 2; wb_result = 16'h0042;
        clk_cycle();
        checks++; if (obs_rdy !== 1'b0) begin errors++; $display("FAIL haz_state_in_ready got=%b want=0", obs_rdy); end
        checks++; if (stall_count !== 8'd1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL haz_stall1 got=%0d/%b want=1/0", stall_count, out_valid); end
        clk_cycle();
        checks++; if (obs_rdy !== 1'b1) begin errors++; $display("FAIL resume_in_ready got=%b want=1", obs_rdy); end
        checks++; if (out_data !== 16'h0042 || out_valid !== 1'b1) begin
            errors++; $display("FAIL load_wb_data got=%h/%b want=0042/1", out_data, out_valid); end
    endtask

    task automatic test_backpressure();
        idle_inputs();
        in_valid = 1; MB = 1; constant = 16'h5555;
        clk_cycle();
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            constant = 16'($urandom); B_data = 16'($urandom);
            clk_cycle();
            checks++; if (obs_rdy !== 1'b0) begin errors++; $display("FAIL hold_in_ready_%0d got=%b want=0", i, obs_rdy); end
            checks++; if (out_data !== 16'h5555 || out_valid !== 1'b1) begin
                errors++; $display("FAIL hold_data_%0d got=%h/%b want=5555/1", i, out_data, out_valid); end
        end
    endtask

    task automatic test_flush_reset();
        // Output still holds 0x5555 with out_ready low.
        flush = 1; in_valid = 1; MB = 1; constant = 16'h7777;
        clk_cycle();
        checks++; if (obs_rdy !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%b want=0", obs_rdy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b want=0", out_valid); end
        idle_inputs();
        in_valid = 1; b_addr = 5; ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 5;
        clk_cycle();                       // enters the stall
        reset = 1;
        clk_cycle();
        checks++; if (stall_count !== 8'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL haz_reset got=%0d/%b want=0/0", stall_count, out_valid); end
        idle_inputs();
        in_valid = 1; MB = 1; constant = 16'h1357;
        clk_cycle();
        checks++; if (obs_rdy !== 1'b1) begin errors++; $display("FAIL post_reset_run got=%b want=1", obs_rdy); end
        checks++; if (out_data !== 16'h1357) begin errors++; $display("FAIL post_reset_data got=%h want=1357", out_data); end
    endtask

    task automatic test_saturation();
        logic [1:0] want [4];
        want = '{2'd1, 2'd2, 2'd3, 2'd3};
        for (int k = 0; k < 4; k++) begin
            idle_inputs();
            in_valid = 1; b_addr = 1; ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 1;
            clk_cycle();
            idle_inputs();
            clk_cycle();
            checks++; if (stall_count2 !== want[k]) begin
                errors++; $display("FAIL sat_stall_%0d got=%0d want=%0d", k, stall_count2, want[k]); end
            checks++; if (stall_count !== 8'(k + 1)) begin
                errors++; $display("FAIL wide_stall_%0d got=%0d want=%0d", k, stall_count, k + 1); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 59) == 0);
            flush      = ($urandom_range(0, 15) == 0);
            in_valid   = ($urandom_range(0, 3) != 0);
            MB         = ($urandom_range(0, 2) == 0);
            b_addr     = 3'($urandom_range(0, 3));
            B_data     = 16'($urandom);
            constant   = 16'($urandom);
            ex_wr_en   = 1'($urandom);
            ex_is_load = 1'($urandom);
            ex_wr_addr = 3'($urandom_range(0, 3));
            ex_result  = 16'($urandom);
            wb_wr_en   = 1'($urandom);
            wb_wr_addr = 3'($urandom_range(0, 3));
            wb_result  = 16'($urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
            clk_cycle();
            checks++; if (obs_rdy !== exp_rdy || obs_rdy2 !== exp_rdy) begin
                errors++; $display("FAIL rnd_in_ready cyc=%0d got=%b/%b want=%b", i, obs_rdy, obs_rdy2, exp_rdy); end
            checks++; if (out_valid !== m_valid || out_valid2 !== m_valid) begin
                errors++; $display("FAIL rnd_valid cyc=%0d got=%b/%b want=%b", i, out_valid, out_valid2, m_valid); end
            checks++; if (out_data !== m_data || out_data2 !== m_data) begin
                errors++; $display("FAIL rnd_data cyc=%0d got=%h/%h want=%h", i, out_data, out_data2, m_data); end
            checks++; if (stall_count !== exp_stall8() || stall_count2 !== exp_stall2()) begin
                errors++; $display("FAIL rnd_stall cyc=%0d got=%0d/%0d want=%0d/%0d", i,
                                   stall_count, stall_count2, exp_stall8(), exp_stall2()); end
        end
    endtask

    initial begin
        m_bubble = 0; m_valid = 0; m_data = '0; m_stall = 0;
        idle_inputs();
        test_reset();
        test_const_select();
        test_forwarding();
        test_load_use();
        test_backpressure();
        test_flush_reset();
        reset = 1;
        clk_cycle();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
